// File: rtl/shift_exec_seq_pkg.sv
// Shared ALU constants: shift mode codes and shifter FSM states.
// Imported by opcode decode and by the sequential shifter.
package shift_exec_seq_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == MODE_SLL) || (m == MODE_SRA) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_exec_seq_step.sv
// Combinational one-bit shift of a WIDTH-bit word selected by mode.
// Illegal modes pass the word through unchanged.
module shift_step
    import shift_exec_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Select the single-position shift for the current mode
    always_comb begin
        dout = din;
        unique case (mode)
            MODE_SLL: dout = {din[WIDTH-2:0], 1'b0};
            MODE_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
            MODE_ROR: dout = {din[0], din[WIDTH-1:1]};
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/shift_exec_seq.sv
// Multi-cycle shifter: one bit per cycle, start/busy/done handshake,
// result and zero flag held until the next operation completes.
module shift_exec_seq
    import shift_exec_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               err
);

    state_t             state;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   nxt;
    logic [SHAMT_W-1:0] cnt;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode (mode_q),
        .din  (work),
        .dout (nxt)
    );

    // Handshake FSM, shift counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode_q <= '0;
            work   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q <= mode;
                        work   <= data_in;
                        cnt    <= shamt;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0 || !mode_legal(mode_q)) begin
                        // nothing to shift: report operand as-is
                        result <= work;
                        zero   <= (work == '0);
                        err    <= !mode_legal(mode_q);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        work <= nxt;
                        cnt  <= cnt - 1'b1;
                        if (cnt == SHAMT_W'(1)) begin
                            result <= nxt;
                            zero   <= (nxt == '0);
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_exec_seq.sv
// Scoreboard bench for shift_exec_seq: ops pushed on accept,
// checked against an arithmetic reference model when done pulses.
module tb_shift_exec_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] data_in;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zero;
    logic        err;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busycnt = 0;

    shift_exec_seq #(
        .WIDTH(16),
        .SHAMT_W(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [15:0] d,
                                   input logic [3:0] s);
        exp_t        r;
        logic [15:0] v;
        logic [31:0] dd;
        v  = d;
        dd = {d, d};
        r.e = 1'b0;
        case (m)
            2'b00: v = d << s;
            2'b01: v = 16'($signed(d) >>> s);
            2'b10: v = dd[15:0] >> s | dd[31:16] << (5'd16 - {1'b0, s});
            default: r.e = 1'b1;
        endcase
        r.res = v;
        r.z   = (v == 16'h0);
        r.lat = (r.e || s == 4'd0) ? 1 : int'(s);
        r.acc = 0;
        return r;
    endfunction

    // Caller is at a negedge with the DUT able to accept
    task automatic go(input logic [1:0] m, input logic [15:0] d, input logic [3:0] s);
        exp_t e;
        start   = 1'b1;
        mode    = m;
        data_in = d;
        shamt   = s;
        e       = model(m, d, s);
        e.acc   = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        mode    = 2'($urandom);
        data_in = 16'($urandom);
        shamt   = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compare each done pulse against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                busycnt = 0;
            end else if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("err", 32'(err), 32'(e.e));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("busy_len", 32'(busycnt), 32'(e.lat));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
                busycnt = 0;
            end else if (busy) begin
                busycnt++;
            end
        end
    end

    initial begin
        start   = 1'b0;
        mode    = 2'b00;
        data_in = 16'h0;
        shamt   = 4'h0;
        rst_n   = 1'b1;
        #13;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go(2'b00, 16'h8001, 4'd1);
        wait_idle();
        go(2'b01, 16'h8000, 4'd4);
        wait_idle();
        go(2'b10, 16'h0001, 4'd15);
        wait_idle();
        go(2'b00, 16'h1234, 4'd0);
        wait_idle();
        go(2'b00, 16'h8000, 4'd1);
        wait_idle();

        // starts during SHIFT must be ignored
        go(2'b01, 16'h9C00, 4'd10);
        for (int i = 0; i < 3; i++) begin
            start   = 1'b1;
            mode    = 2'b00;
            data_in = 16'hFFFF;
            shamt   = 4'd2;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        wait_idle();

        // back-to-back: start in the DONE cycle
        go(2'b00, 16'h00F0, 4'd3);
        wait_done();
        go(2'b10, 16'h1235, 4'd2);
        wait_done();
        go(2'b11, 16'h5555, 4'd7);
        wait_idle();

        go(2'b11, 16'hABCD, 4'd5);
        wait_idle();

        // reset mid-operation: no done may follow
        go(2'b00, 16'h0F0F, 4'd8);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'h0);
        chk("midrst_zero", 32'(zero), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        go(2'b01, 16'h4321, 4'd3);
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            go(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
